// File: rtl/dram_if_pkg.sv
// Shared definitions for the DDR user-port arbiter: command encodings and FSM states.
package dram_if_pkg;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {IDLE, WR, RD} arbState_t;
endpackage

// File: rtl/dram_arbiter_if.sv
// Memory-controller user port (command, write-data and read-return channels).
interface dram_arbiter_if #(
    parameter int MEM_IF_WIDTH = 128,
    parameter int ADX_WIDTH    = 27
);
    logic                    app_en;
    logic [2:0]              app_cmd;
    logic [ADX_WIDTH-1:0]    app_addr;
    logic                    app_rdy;
    logic [MEM_IF_WIDTH-1:0] app_wdf_data;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic                    app_wdf_rdy;
    logic [MEM_IF_WIDTH-1:0] app_rd_data;
    logic                    app_rd_data_valid;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/dram_rd_tracker.sv
// Counts issued-but-unreturned reads, flags unexpected returns and registers read data.
module dram_rd_tracker #(
    parameter int MEM_IF_WIDTH = 128,
    parameter int CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    issue,
    input  logic                    retValid,
    input  logic [MEM_IF_WIDTH-1:0] retData,
    output logic [CNT_W-1:0]        outstanding,
    output logic [MEM_IF_WIDTH-1:0] rdData,
    output logic                    rdDataValid,
    output logic                    underflow
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
            rdData      <= '0;
            rdDataValid <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            rdData      <= retData;
            rdDataValid <= retValid;
            // A return with nothing in flight is a controller protocol error; keep it visible.
            if (retValid && outstanding == '0)
                underflow <= 1'b1;
            if (issue && !retValid)
                outstanding <= outstanding + 1'b1;
            else if (!issue && retValid && outstanding != '0)
                outstanding <= outstanding - 1'b1;
        end
    end
endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the DDR user port between the sample packer (writes, priority) and the
// capture-upload engine (reads), with a read-starvation bound and an outstanding-read cap.
module dram_arbiter
    import dram_if_pkg::*;
#(
    parameter int MEM_IF_WIDTH    = 128,
    parameter int ADX_WIDTH       = 27,
    parameter int STARVE_LIMIT    = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_req,
    input  logic [ADX_WIDTH-1:0]    wr_adx,
    input  logic [MEM_IF_WIDTH-1:0] wr_data,
    output logic                    wr_allowed,
    input  logic                    rd_req,
    input  logic [ADX_WIDTH-1:0]    rd_adx,
    output logic                    rd_ack,
    output logic [MEM_IF_WIDTH-1:0] rd_data,
    output logic                    rd_data_valid,
    dram_arbiter_if.master          app,
    output logic                    busy,
    output logic                    rd_underflow
);
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]      MAX_OUT    = 4'(MAX_OUTSTANDING);

    arbState_t                 state, stateNxt;
    logic [SW-1:0]             streak, streakNxt;
    logic                      cmdDone, cmdDoneNxt, dataDone, dataDoneNxt;
    logic [ADX_WIDTH-1:0]      addrReg;
    logic [MEM_IF_WIDTH-1:0]   dataReg;
    logic [3:0]                outstanding;
    logic                      rdRoom, starve, wrAccept, cmdHs, dataHs, rdIssue;

    // wr_allowed must not look at wr_req, otherwise the requester sees a comb loop.
    assign rdRoom     = outstanding < MAX_OUT;
    assign starve     = rd_req & (streak >= STREAK_MAX) & rdRoom;
    assign wr_allowed = (state == IDLE) & ~starve;
    assign wrAccept   = wr_req & wr_allowed;
    assign rd_ack     = (state == IDLE) & rd_req & rdRoom & ~wrAccept;

    assign cmdHs   = (state == WR) & ~cmdDone & app.app_rdy;
    assign dataHs  = (state == WR) & ~dataDone & app.app_wdf_rdy;
    assign rdIssue = (state == RD) & app.app_rdy;

    assign app.app_addr     = addrReg;
    assign app.app_wdf_data = dataReg;
    assign app.app_wdf_end  = app.app_wdf_wren;
    assign busy             = (state != IDLE) | (outstanding != '0);

    always_comb begin
        stateNxt         = state;
        streakNxt        = streak;
        cmdDoneNxt       = cmdDone;
        dataDoneNxt      = dataDone;
        app.app_en       = 1'b0;
        app.app_cmd      = APP_CMD_WRITE;
        app.app_wdf_wren = 1'b0;
        case (state)
            IDLE: begin
                cmdDoneNxt  = 1'b0;
                dataDoneNxt = 1'b0;
                if (wrAccept) begin
                    stateNxt  = WR;
                    streakNxt = !rd_req ? '0 : (streak == STREAK_MAX ? streak : streak + 1'b1);
                end else if (rd_ack) begin
                    stateNxt  = RD;
                    streakNxt = '0;
                end else if (!rd_req) begin
                    streakNxt = '0;
                end
            end
            WR: begin
                // Command and data channels complete independently, possibly together.
                app.app_en       = ~cmdDone;
                app.app_wdf_wren = ~dataDone;
                cmdDoneNxt       = cmdDone | cmdHs;
                dataDoneNxt      = dataDone | dataHs;
                if (cmdDoneNxt && dataDoneNxt)
                    stateNxt = IDLE;
            end
            RD: begin
                app.app_en  = 1'b1;
                app.app_cmd = APP_CMD_READ;
                if (app.app_rdy)
                    stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            streak   <= '0;
            cmdDone  <= 1'b0;
            dataDone <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
        end else begin
            state    <= stateNxt;
            streak   <= streakNxt;
            cmdDone  <= cmdDoneNxt;
            dataDone <= dataDoneNxt;
            if (wrAccept) begin
                addrReg <= wr_adx;
                dataReg <= wr_data;
            end else if (rd_ack) begin
                addrReg <= rd_adx;
            end
        end
    end

    dram_rd_tracker #(
        .MEM_IF_WIDTH(MEM_IF_WIDTH),
        .CNT_W       (4)
    ) rdTracker (
        .clk        (clk),
        .resetn     (resetn),
        .issue      (rdIssue),
        .retValid   (app.app_rd_data_valid),
        .retData    (app.app_rd_data),
        .outstanding(outstanding),
        .rdData     (rd_data),
        .rdDataValid(rd_data_valid),
        .underflow  (rd_underflow)
    );
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic, every output checked
// each cycle against a transaction-level model of the arbiter.
module tb_dram_arbiter;
    localparam int W  = 128;
    localparam int AW = 27;
    localparam int SL = 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          wr_req, rd_req, wr_allowed, rd_ack, rd_data_valid, busy, rd_underflow;
    logic [AW-1:0] wr_adx, rd_adx;
    logic [W-1:0]  wr_data, rd_data;

    dram_arbiter_if #(.MEM_IF_WIDTH(W), .ADX_WIDTH(AW)) app ();

    dram_arbiter #(
        .MEM_IF_WIDTH(W), .ADX_WIDTH(AW), .STARVE_LIMIT(SL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_req(wr_req), .wr_adx(wr_adx), .wr_data(wr_data), .wr_allowed(wr_allowed),
        .rd_req(rd_req), .rd_adx(rd_adx), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .app(app), .busy(busy), .rd_underflow(rd_underflow)
    );

    int errors = 0;
    int checks = 0;

    // Model: one pending transaction (write with cmd/data still owed, or a read command),
    // a count of reads in flight, the write streak and the last return.
    bit          mWr, mCmdLeft, mDatLeft, mRd, mUnder, mRdv;
    logic [AW-1:0] mAddr;
    logic [W-1:0]  mData, mRdd;
    int          mOut, mStreak;
    bit          lastWrAcc, lastRdAck;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit mIdle();
        return !mWr && !mRd;
    endfunction

    function automatic bit eWrAllowed();
        return mIdle() && !(rd_req && mStreak >= SL && mOut < MO);
    endfunction

    function automatic bit eRdAck();
        return mIdle() && rd_req && mOut < MO && !(wr_req && eWrAllowed());
    endfunction

    task automatic model_reset();
        mWr = 0; mCmdLeft = 0; mDatLeft = 0; mRd = 0; mUnder = 0; mRdv = 0;
        mAddr = '0; mData = '0; mRdd = '0; mOut = 0; mStreak = 0;
        lastWrAcc = 0; lastRdAck = 0;
    endtask

    task automatic compare_all();
        chk("wr_allowed",    W'(wr_allowed),        W'(eWrAllowed()));
        chk("rd_ack",        W'(rd_ack),            W'(eRdAck()));
        chk("app_en",        W'(app.app_en),        W'(mWr ? mCmdLeft : mRd));
        chk("app_cmd",       W'(app.app_cmd),       W'(mRd ? 3'b001 : 3'b000));
        chk("app_addr",      W'(app.app_addr),      W'(mAddr));
        chk("app_wdf_data",  app.app_wdf_data,      mData);
        chk("app_wdf_wren",  W'(app.app_wdf_wren),  W'(mWr && mDatLeft));
        chk("app_wdf_end",   W'(app.app_wdf_end),   W'(mWr && mDatLeft));
        chk("busy",          W'(busy),              W'(!mIdle() || mOut != 0));
        chk("rd_data_valid", W'(rd_data_valid),     W'(mRdv));
        chk("rd_data",       rd_data,               mRdd);
        chk("rd_underflow",  W'(rd_underflow),      W'(mUnder));
    endtask

    task automatic model_update();
        bit wa, ra, issue, ret;
        wa = wr_req && eWrAllowed();
        ra = eRdAck();
        issue = 0;
        ret = app.app_rd_data_valid;
        lastWrAcc = wa;
        lastRdAck = ra;
        if (mIdle()) begin
            if (wa) begin
                mWr = 1; mCmdLeft = 1; mDatLeft = 1; mAddr = wr_adx; mData = wr_data;
                mStreak = rd_req ? ((mStreak + 1 > SL) ? SL : mStreak + 1) : 0;
            end else if (ra) begin
                mRd = 1; mAddr = rd_adx; mStreak = 0;
            end else if (!rd_req) begin
                mStreak = 0;
            end
        end else if (mWr) begin
            if (app.app_rdy) mCmdLeft = 0;
            if (app.app_wdf_rdy) mDatLeft = 0;
            if (!mCmdLeft && !mDatLeft) mWr = 0;
        end else if (app.app_rdy) begin
            mRd = 0;
            issue = 1;
        end
        if (ret && mOut == 0) mUnder = 1;
        if (issue && !ret) mOut++;
        else if (ret && !issue && mOut > 0) mOut--;
        mRdv = ret;
        mRdd = app.app_rd_data;
    endtask

    task automatic tick();
        #1;
        compare_all();
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, acks;
        bit done;
        wr_req = 0; rd_req = 0; wr_adx = '0; rd_adx = '0; wr_data = '0;
        app.app_rdy = 0; app.app_wdf_rdy = 0;
        app.app_rd_data = {4{32'hDEAD_BEEF}}; app.app_rd_data_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset app_en",        W'(app.app_en),       W'(1'b0));
        chk("reset app_wdf_wren",  W'(app.app_wdf_wren), W'(1'b0));
        chk("reset app_addr",      W'(app.app_addr),     W'(0));
        chk("reset busy",          W'(busy),             W'(1'b0));
        chk("reset rd_data",       rd_data,              W'(0));
        chk("reset rd_underflow",  W'(rd_underflow),     W'(1'b0));
        @(negedge clk);
        resetn = 1;

        // Single write with both channels ready.
        app.app_rdy = 1; app.app_wdf_rdy = 1;
        wr_adx = 27'h8; wr_data = {16{8'hA5}}; wr_req = eWrAllowed();
        #1 chk("t1 wr_allowed at accept", W'(wr_allowed), W'(1'b1));
        tick();
        wr_req = 0;
        #1;
        chk("t1 app_en",       W'(app.app_en),       W'(1'b1));
        chk("t1 app_addr",     W'(app.app_addr),     W'(27'h8));
        chk("t1 app_wdf_data", app.app_wdf_data,     {16{8'hA5}});
        chk("t1 wren",         W'(app.app_wdf_wren), W'(1'b1));
        chk("t1 wr_allowed low", W'(wr_allowed),     W'(1'b0));
        tick();
        #1 chk("t1 wr_allowed back", W'(wr_allowed), W'(1'b1));
        tick();

        // Split handshake: command at cycle 1, data held off until cycle 4.
        app.app_rdy = 1; app.app_wdf_rdy = 0;
        wr_adx = 27'h123; wr_data = {4{32'h1234_5678}}; wr_req = 1;
        tick();
        wr_req = 0;
        #1 chk("t2 c1 app_en", W'(app.app_en), W'(1'b1));
        tick();
        app.app_rdy = 0;
        #1;
        chk("t2 c2 app_en", W'(app.app_en),       W'(1'b0));
        chk("t2 c2 wren",   W'(app.app_wdf_wren), W'(1'b1));
        tick();
        tick();
        app.app_wdf_rdy = 1;
        #1 chk("t2 c4 wren", W'(app.app_wdf_wren), W'(1'b1));
        tick();
        #1 chk("t2 c5 idle", W'(wr_allowed), W'(1'b1));
        tick();

        // Starvation bound: writes at every opportunity while a read waits.
        app.app_rdy = 1; app.app_wdf_rdy = 1;
        rd_req = 1; rd_adx = 27'h40; n = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            wr_req = eWrAllowed(); wr_adx = AW'(c); wr_data = {4{$urandom}};
            tick();
            if (lastRdAck) begin done = 1; rd_req = 0; end
            else if (lastWrAcc) n++;
        end
        chk("t3 forced read seen", W'(done), W'(1'b1));
        chk("t3 writes before forced read", W'(n), W'(8));
        r = 0;
        for (int c = 0; c < 3; c++) begin
            wr_req = eWrAllowed(); wr_adx = AW'(c + 100);
            tick();
            if (lastWrAcc) r++;
        end
        chk("t3 writes resume", W'(r), W'(1));
        wr_req = 0;
        tick(); tick();

        // Outstanding cap: drain the earlier read, then request five reads with no returns.
        app.app_rd_data = {4{32'hCAFE_0001}}; app.app_rd_data_valid = 1;
        tick();
        app.app_rd_data_valid = 0;
        rd_req = 1; rd_adx = 27'd100; acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (lastRdAck) begin acks++; rd_adx = rd_adx + 1'b1; end
        end
        chk("t4 acks at cap", W'(acks), W'(4));
        #1 chk("t4 fifth held", W'(rd_ack), W'(1'b0));
        app.app_rd_data = {4{32'h0BAD_F00D}}; app.app_rd_data_valid = 1;
        tick();
        app.app_rd_data_valid = 0;
        #1;
        chk("t4 fifth acked", W'(rd_ack),        W'(1'b1));
        chk("t4 return valid", W'(rd_data_valid), W'(1'b1));
        chk("t4 return data", rd_data,           {4{32'h0BAD_F00D}});
        tick();
        rd_req = 0;
        app.app_rd_data_valid = 1;
        repeat (4) tick();
        app.app_rd_data_valid = 0;
        tick();
        #1 chk("t4 drained busy", W'(busy), W'(1'b0));
        tick();

        // Underflow: a return with nothing in flight, then verify it sticks.
        app.app_rd_data_valid = 1;
        tick();
        app.app_rd_data_valid = 0;
        #1 chk("t5 underflow set", W'(rd_underflow), W'(1'b1));
        repeat (3) tick();
        #1 chk("t5 underflow sticky", W'(rd_underflow), W'(1'b1));
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            app.app_rdy     = ($urandom % 4) != 0;
            app.app_wdf_rdy = ($urandom % 3) != 0;
            if (!rd_req && ($urandom % 3) == 0) begin
                rd_req = 1; rd_adx = AW'($urandom);
            end
            wr_req  = (($urandom % 4) != 0) && eWrAllowed();
            wr_adx  = AW'($urandom);
            wr_data = {4{$urandom}};
            app.app_rd_data = {4{$urandom}};
            app.app_rd_data_valid = (mOut > 0) && (($urandom % 3) == 0);
            tick();
            if (lastRdAck) rd_req = 0;
        end

        // Reset in the middle of a stalled write.
        wr_req = 0; rd_req = 0; app.app_rd_data_valid = 0;
        app.app_rdy = 1; app.app_wdf_rdy = 1;
        for (int c = 0; c < 20 && !mIdle(); c++) tick();
        app.app_rdy = 0; app.app_wdf_rdy = 0;
        wr_adx = 27'h5A5; wr_data = {4{32'h7777_7777}}; wr_req = eWrAllowed();
        tick();
        wr_req = 0;
        tick();
        #1 chk("t6 underflow before reset", W'(rd_underflow), W'(1'b1));
        resetn = 0;
        #1;
        chk("t6 app_en",       W'(app.app_en),       W'(1'b0));
        chk("t6 app_cmd",      W'(app.app_cmd),      W'(3'b000));
        chk("t6 app_wdf_wren", W'(app.app_wdf_wren), W'(1'b0));
        chk("t6 app_wdf_end",  W'(app.app_wdf_end),  W'(1'b0));
        chk("t6 app_addr",     W'(app.app_addr),     W'(0));
        chk("t6 app_wdf_data", app.app_wdf_data,     W'(0));
        chk("t6 busy",         W'(busy),             W'(1'b0));
        chk("t6 rd_underflow", W'(rd_underflow),     W'(1'b0));
        chk("t6 rd_data_valid", W'(rd_data_valid),   W'(1'b0));
        model_reset();
        @(negedge clk);
        resetn = 1;
        app.app_rdy = 1; app.app_wdf_rdy = 1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DDR user command/data port between two requesters.
  - Write requester: the sample packer, which is latency-critical and has priority.
  - Read requester: the capture-upload engine.
- Sequences each granted request into the memory controller's command, write-data and read-return handshakes.
- Bounds read starvation and the number of outstanding reads.

Parameters:
- MEM_IF_WIDTH, 128, width of memory data path and both data ports.
- ADX_WIDTH, 27, memory address width.
- STARVE_LIMIT, 8, consecutive write grants allowed while rd_req is pending before one read is forced.
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned reads (1..15).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_req  in  1  write request; valid only in a cycle where wr_allowed=1
- wr_adx  in  ADX_WIDTH  write address
- wr_data  in  MEM_IF_WIDTH  write data
- wr_allowed  out  1  arbiter can accept a write this cycle
- rd_req  in  1  read request; level, held with rd_adx until rd_ack
- rd_adx  in  ADX_WIDTH  read address
- rd_ack  out  1  read request accepted this cycle
- rd_data  out  MEM_IF_WIDTH  returned read data
- rd_data_valid  out  1  rd_data valid
- app_en  out  1  memory command valid
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  ADX_WIDTH  command address
- app_rdy  in  1  command accepted when app_en & app_rdy
- app_wdf_data  out  MEM_IF_WIDTH  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  last beat, always equal to app_wdf_wren
- app_wdf_rdy  in  1  data accepted when app_wdf_wren & app_wdf_rdy
- app_rd_data  in  MEM_IF_WIDTH  read return data
- app_rd_data_valid  in  1  read return valid
- busy  out  1  state!=IDLE or outstanding!=0
- rd_underflow  out  1  sticky: app_rd_data_valid seen with outstanding==0

Behaviour:
- Reset and clocking
  - Reset is asynchronous, active-low, on resetn. One clock domain, clk.
  - Reset values: state=IDLE, all app_* outputs 0, rd_data=0, rd_data_valid=0, rd_underflow=0, outstanding=0, streak=0, address/data registers 0.
  - Reset mid-transaction drops the in-flight command and clears the outstanding count.
- States: IDLE, WR, RD.
- wr_allowed
  - Combinational: (state==IDLE) & ~(rd_req & streak>=STARVE_LIMIT & outstanding<MAX_OUTSTANDING).
  - Never depends on wr_req, so there is no combinational loop with the requester.
- Write accept
  - Condition: wr_req & wr_allowed.
  - Latch wr_adx/wr_data, go to WR.
  - streak <= streak+1 if rd_req, else 0. Saturates at STARVE_LIMIT.
- rd_ack
  - Combinational: (state==IDLE) & rd_req & outstanding<MAX_OUTSTANDING & ~(wr_req & wr_allowed).
  - On rd_ack: latch rd_adx, go to RD, streak<=0.
- Simultaneous requests
  - Write wins unless the starve condition holds, in which case wr_allowed is already 0.
- IDLE with no accept: streak<=0 if ~rd_req.
- WR state
  - app_en=~cmd_done, app_cmd=000.
  - app_wdf_wren=app_wdf_end=~data_done.
  - cmd_done and data_done set independently on their handshakes.
  - Leave to IDLE in the cycle the last outstanding handshake completes; both may complete in the same cycle.
  - Minimum WR occupancy is 1 cycle, so the next wr_allowed comes 2 cycles after an accept.
- RD state
  - app_en=1, app_cmd=001 until app_rdy, then go to IDLE.
- Outstanding counter
  - +1 on read command accept, -1 on app_rd_data_valid, unchanged when both occur.
  - Decrement at 0 is suppressed and sets rd_underflow.
- Read return
  - rd_data/rd_data_valid are app_rd_data/app_rd_data_valid registered: 1-cycle latency, in order, no backpressure.
- app_addr/app_wdf_data drive the latched registers and are stable throughout a command.

Decomposition:
- Shared package dram_if_pkg:
  - APP_CMD_WRITE=3'b000, APP_CMD_READ=3'b001.
  - State encoding enum {IDLE,WR,RD}.
- One natural sub-module, dram_rd_tracker: the outstanding counter, underflow flag and read-return register stage.
- Arbitration FSM stays in the top module.

Test Plan:
- Single write, app_rdy=app_wdf_rdy=1: wr_req at wr_allowed, adx=0x8, data=0xA5..A5 -> one cycle app_en=1, app_cmd=0, app_addr=0x8, app_wdf_wren=app_wdf_end=1; wr_allowed back 2 cycles after accept.
- Split handshake: app_rdy high at cycle 1, app_wdf_rdy held low until cycle 4 -> app_en drops after cycle 1, wren held through cycle 4, IDLE at cycle 5, data and address unchanged throughout.
- Starvation: continuous writes plus rd_req, STARVE_LIMIT=8 -> exactly 8 write accepts, then wr_allowed=0 for one IDLE cycle with rd_ack=1, then writes resume.
- Outstanding limit: 5 back-to-back reads with no returns, MAX_OUTSTANDING=4 -> 4 rd_ack; 5th held until the first app_rd_data_valid, then acked. rd_data_valid follows each return by 1 cycle.
- Underflow and reset: app_rd_data_valid with no reads -> rd_underflow=1 sticky. resetn asserted during WR with app_rdy=0 -> all outputs 0 immediately, busy=0, rd_underflow=0.
